// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: per-pin direction, 2-flop synchroniser, debounce filter,
// and rise/fall edge capture into a write-1-to-clear status register driving one level interrupt.
module gpio_bank #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      address_in,
    input  logic             sel_in,
    input  logic             read_in,
    output logic [31:0]      read_value_out,
    input  logic [3:0]       write_mask_in,
    input  logic [31:0]      write_value_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq_out
);

    localparam int DMAX = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES : 1;
    localparam int CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DMAX - 1);

    localparam logic [2:0] A_OUT    = 3'd0;
    localparam logic [2:0] A_DIR    = 3'd1;
    localparam logic [2:0] A_IN     = 3'd2;
    localparam logic [2:0] A_RISE   = 3'd3;
    localparam logic [2:0] A_FALL   = 3'd4;
    localparam logic [2:0] A_STATUS = 3'd5;
    localparam logic [2:0] A_SET    = 3'd6;
    localparam logic [2:0] A_CLR    = 3'd7;

    logic [WIDTH-1:0] r_out, r_dir, r_in, r_rise_en, r_fall_en, r_status;
    logic [WIDTH-1:0] r_sync1, r_sync2;
    logic [CW-1:0]    r_cnt [WIDTH];

    logic [WIDTH-1:0] w_in_nxt;
    logic [CW-1:0]    w_cnt_nxt [WIDTH];
    logic [31:0]      w_lane;
    logic [WIDTH-1:0] w_bm, w_wd, w_event, w_clr;
    logic [31:0]      w_rd;
    logic [2:0]       w_idx;
    logic             w_wr;
    logic             w_unused;

    assign w_lane = {{8{write_mask_in[3]}}, {8{write_mask_in[2]}},
                     {8{write_mask_in[1]}}, {8{write_mask_in[0]}}};
    assign w_bm   = w_lane[WIDTH-1:0];
    assign w_wd   = write_value_in[WIDTH-1:0] & w_bm;
    assign w_wr   = sel_in & (|write_mask_in);
    assign w_idx  = address_in[4:2];

    // A synced level must differ from IN for DMAX consecutive cycles before it is accepted
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_in_nxt[i]  = r_in[i];
            w_cnt_nxt[i] = r_cnt[i];
            if (r_sync2[i] == r_in[i]) begin
                w_cnt_nxt[i] = '0;
            end else if (r_cnt[i] == CNT_LAST) begin
                w_in_nxt[i]  = r_sync2[i];
                w_cnt_nxt[i] = '0;
            end else begin
                w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end
        end
    end

    assign w_event = (w_in_nxt & ~r_in & r_rise_en) | (~w_in_nxt & r_in & r_fall_en);
    assign w_clr   = (w_wr && (w_idx == A_STATUS)) ? w_wd : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out     <= '0;
            r_dir     <= '0;
            r_in      <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_status  <= '0;
            r_sync1   <= '0;
            r_sync2   <= '0;
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1  <= gpio_in;
            r_sync2  <= r_sync1;
            r_in     <= w_in_nxt;
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= w_cnt_nxt[i];
            // Event is ORed after the clear so a same-edge capture wins
            r_status <= (r_status & ~w_clr) | w_event;
            if (w_wr) begin
                case (w_idx)
                    A_OUT:   r_out     <= (r_out & ~w_bm) | w_wd;
                    A_DIR:   r_dir     <= (r_dir & ~w_bm) | w_wd;
                    A_RISE:  r_rise_en <= (r_rise_en & ~w_bm) | w_wd;
                    A_FALL:  r_fall_en <= (r_fall_en & ~w_bm) | w_wd;
                    A_SET:   r_out     <= r_out | w_wd;
                    A_CLR:   r_out     <= r_out & ~w_wd;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_rd = '0;
        if (sel_in) begin
            case (w_idx)
                A_OUT:    w_rd[WIDTH-1:0] = r_out;
                A_DIR:    w_rd[WIDTH-1:0] = r_dir;
                A_IN:     w_rd[WIDTH-1:0] = r_in;
                A_RISE:   w_rd[WIDTH-1:0] = r_rise_en;
                A_FALL:   w_rd[WIDTH-1:0] = r_fall_en;
                A_STATUS: w_rd[WIDTH-1:0] = r_status;
                default:  ;
            endcase
        end
    end

    assign read_value_out = w_rd;
    assign ready_out      = sel_in;
    assign gpio_out       = r_out;
    assign gpio_oe        = r_dir;
    assign irq_out        = |r_status;

    // Reads have no side effects; upper address and data bits are not decoded
    assign w_unused = &{1'b0, address_in[31:5], address_in[1:0], read_in, write_value_in, w_lane};

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: an 8-pin unfiltered instance and a 12-pin instance with a 4-cycle debounce.
module tb_gpio_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        rd_stb;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        sel0, sel1;
    logic [31:0] rdv0, rdv1;
    logic        ready0, ready1;
    logic [7:0]  gpio_in0, gpio_out0, gpio_oe0;
    logic [11:0] gpio_in1, gpio_out1, gpio_oe1;
    logic        irq0, irq1;
    logic [31:0] v;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gpio_bank #(.WIDTH(8), .DEBOUNCE_CYCLES(0)) u0 (
        .clk(clk), .reset(reset), .address_in(address), .sel_in(sel0), .read_in(rd_stb),
        .read_value_out(rdv0), .write_mask_in(wmask), .write_value_in(wdata),
        .ready_out(ready0), .gpio_in(gpio_in0), .gpio_out(gpio_out0), .gpio_oe(gpio_oe0),
        .irq_out(irq0)
    );

    gpio_bank #(.WIDTH(12), .DEBOUNCE_CYCLES(4)) u1 (
        .clk(clk), .reset(reset), .address_in(address), .sel_in(sel1), .read_in(rd_stb),
        .read_value_out(rdv1), .write_mask_in(wmask), .write_value_in(wdata),
        .ready_out(ready1), .gpio_in(gpio_in1), .gpio_out(gpio_out1), .gpio_oe(gpio_oe1),
        .irq_out(irq1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input int dev, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        @(negedge clk);
        address = a; wmask = m; wdata = d;
        sel0 = (dev == 0); sel1 = (dev == 1);
        @(posedge clk);
        #1;
        sel0 = 1'b0; sel1 = 1'b0; wmask = 4'h0;
    endtask

    // Combinational read taken between clock edges
    task automatic rd(input int dev, input logic [31:0] a, output logic [31:0] val);
        address = a; rd_stb = 1'b1;
        sel0 = (dev == 0); sel1 = (dev == 1);
        #1;
        val = (dev == 0) ? rdv0 : rdv1;
        sel0 = 1'b0; sel1 = 1'b0; rd_stb = 1'b0;
    endtask

    initial begin
        reset = 1'b0; address = '0; rd_stb = 1'b0; wmask = 4'h0; wdata = '0;
        sel0 = 1'b0; sel1 = 1'b0; gpio_in0 = 8'hFF; gpio_in1 = 12'h000;

        // Reset state with all u0 pins high
        #2;
        sel0 = 1'b1; #1; chk("rst_ready", {31'b0, ready0}, 32'h1); sel0 = 1'b0;
        rd(0, 32'h08, v); chk("rst_in", v, 32'h0);
        chk("rst_gpio_out", {24'b0, gpio_out0}, 32'h0);
        chk("rst_gpio_oe", {24'b0, gpio_oe0}, 32'h0);
        chk("rst_irq", {31'b0, irq0}, 32'h0);
        chk("desel_read", rdv0, 32'h0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rd(0, 32'h08, v); chk("in_at_e1", v, 32'h0);
        @(posedge clk); #1;
        rd(0, 32'h08, v); chk("in_at_e2", v, 32'hFF);
        rd(0, 32'h14, v); chk("status_after_rst", v, 32'h0);
        chk("irq_after_rst", {31'b0, irq0}, 32'h0);

        // OUT / SET / CLR
        wr(0, 32'h00, 4'b0001, 32'h5A);
        wr(0, 32'h18, 4'b0001, 32'h01);
        wr(0, 32'h1C, 4'b0001, 32'h10);
        chk("gpio_out_setclr", {24'b0, gpio_out0}, 32'h4B);
        rd(0, 32'h00, v); chk("read_out", v, 32'h4B);
        rd(0, 32'h18, v); chk("read_set", v, 32'h0);
        rd(0, 32'h1C, v); chk("read_clr", v, 32'h0);

        // Rising-edge capture and W1C on u0
        wr(0, 32'h0C, 4'hF, 32'h03);
        rd(0, 32'h0C, v); chk("read_rise_en", v, 32'h03);
        @(negedge clk); gpio_in0 = 8'hFC;
        repeat (4) @(posedge clk);
        #1; rd(0, 32'h14, v); chk("fall_not_enabled", v, 32'h0);
        @(negedge clk); gpio_in0 = 8'hFF;
        repeat (4) @(posedge clk);
        #1; rd(0, 32'h14, v); chk("status_rise2", v, 32'h03);
        chk("irq_set", {31'b0, irq0}, 32'h1);
        wr(0, 32'h14, 4'h1, 32'h01);
        rd(0, 32'h14, v); chk("w1c_bit0", v, 32'h02);
        @(negedge clk); gpio_in0 = 8'hFD;
        repeat (4) @(posedge clk);
        @(negedge clk); gpio_in0 = 8'hFF;
        @(posedge clk); @(posedge clk);
        wr(0, 32'h14, 4'h1, 32'h02);
        rd(0, 32'h14, v); chk("set_wins_w1c", v, 32'h02);
        wr(0, 32'h14, 4'h1, 32'h02);
        rd(0, 32'h14, v); chk("w1c_bit1", v, 32'h0);
        chk("irq_clear", {31'b0, irq0}, 32'h0);

        // Debounce on u1 (4 cycles)
        wr(1, 32'h0C, 4'hF, 32'h01);
        wr(1, 32'h10, 4'hF, 32'h00);
        @(negedge clk); gpio_in1 = 12'h001;
        repeat (3) @(negedge clk);
        gpio_in1 = 12'h000;
        repeat (10) @(posedge clk);
        #1; rd(1, 32'h08, v); chk("short_pulse_in", v, 32'h0);
        rd(1, 32'h14, v); chk("short_pulse_status", v, 32'h0);
        @(negedge clk); gpio_in1 = 12'h001;
        repeat (5) @(posedge clk);
        #1; rd(1, 32'h08, v); chk("in_at_e4", v, 32'h0);
        @(posedge clk);
        #1; rd(1, 32'h08, v); chk("in_at_e5", v, 32'h1);
        rd(1, 32'h14, v); chk("status_long_pulse", v, 32'h1);
        chk("irq1_set", {31'b0, irq1}, 32'h1);
        @(negedge clk); gpio_in1 = 12'h000;
        repeat (10) @(posedge clk);
        #1; rd(1, 32'h08, v); chk("in_released", v, 32'h0);
        rd(1, 32'h14, v); chk("no_fall_capture", v, 32'h1);
        wr(1, 32'h14, 4'hF, 32'h01);
        rd(1, 32'h14, v); chk("u1_w1c", v, 32'h0);

        // Byte-lane masking and WIDTH clipping on u1
        wr(1, 32'h04, 4'b0010, 32'hFFFF_FFFF);
        rd(1, 32'h04, v); chk("dir_lane1", v, 32'h0000_0F00);
        chk("gpio_oe1", {20'b0, gpio_oe1}, 32'h0000_0F00);
        wr(1, 32'h00, 4'hF, 32'hFFFF_FFFF);
        rd(1, 32'h00, v); chk("out_clipped", v, 32'h0000_0FFF);
        wr(1, 32'h08, 4'hF, 32'hFFFF_FFFF);
        rd(1, 32'h08, v); chk("in_write_ignored", v, 32'h0);

        // Reset mid-debounce with a pending status bit
        wr(1, 32'h0C, 4'hF, 32'h80);
        @(negedge clk); gpio_in1 = 12'h080;
        repeat (8) @(posedge clk);
        #1; rd(1, 32'h14, v); chk("status_pin7", v, 32'h80);
        @(negedge clk); gpio_in1 = 12'h081;
        @(posedge clk); @(posedge clk);
        @(negedge clk); #2 reset = 1'b0;
        #1;
        chk("arst_gpio_out", {20'b0, gpio_out1}, 32'h0);
        chk("arst_gpio_oe", {20'b0, gpio_oe1}, 32'h0);
        chk("arst_irq", {31'b0, irq1}, 32'h0);
        rd(1, 32'h14, v); chk("arst_status", v, 32'h0);
        rd(1, 32'h08, v); chk("arst_in", v, 32'h0);
        @(negedge clk); reset = 1'b1;
        repeat (8) @(posedge clk);
        #1; rd(1, 32'h08, v); chk("post_rst_in", v, 32'h081);
        rd(1, 32'h14, v); chk("post_rst_status", v, 32'h0);
        chk("post_rst_irq", {31'b0, irq1}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
